// File: rtl/nmi_pkg.sv
// Shared types and constants for the NMI arbiter: FSM state encoding and the
// idle/timeout read-data fill pattern.
package nmi_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } nmi_state_e;

    localparam logic [15:0] C0DE_FILL = 16'hC0DE;

endpackage

// File: rtl/nmi_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr,
// wrapping modulo N_MASTERS.
module nmi_rr_picker #(
    parameter int N_MASTERS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [N_MASTERS-1:0] grant_onehot,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 any
);

    int cand;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        cand         = 0;
        for (int k = 0; k < N_MASTERS; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_MASTERS) cand = cand - N_MASTERS;
            if (!any && req[IDX_W'(cand)]) begin
                any                         = 1'b1;
                grant_idx                   = IDX_W'(cand);
                grant_onehot[IDX_W'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nmi_arbiter.sv
// Round-robin arbiter funnelling N NMI requesters onto one downstream port,
// one transaction at a time, with an optional per-transaction timeout.
module nmi_arbiter
    import nmi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int N_MASTERS      = 2,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int WSTRB_WIDTH    = (DATA_WIDTH - 1) / 8 + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_MASTERS-1:0]              s_nmi_valid,
    input  logic [N_MASTERS-1:0]              s_nmi_instr,
    output logic [N_MASTERS-1:0]              s_nmi_ready,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]   s_nmi_addr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]   s_nmi_wdata,
    input  logic [N_MASTERS*WSTRB_WIDTH-1:0]  s_nmi_wstrb,
    output logic [N_MASTERS*DATA_WIDTH-1:0]   s_nmi_rdata,
    output logic                              m_nmi_valid,
    output logic                              m_nmi_instr,
    input  logic                              m_nmi_ready,
    output logic [ADDR_WIDTH-1:0]             m_nmi_addr,
    output logic [DATA_WIDTH-1:0]             m_nmi_wdata,
    output logic [WSTRB_WIDTH-1:0]            m_nmi_wstrb,
    input  logic [DATA_WIDTH-1:0]             m_nmi_rdata,
    output logic                              timeout_err,
    output logic                              dbg_busy
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [DATA_WIDTH-1:0] FILL = {(DATA_WIDTH / 16){C0DE_FILL}};

    nmi_state_e             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d, rr_q, rr_d, next_ptr;
    logic [N_MASTERS-1:0]   grant_oh_q, grant_oh_d, pick_oh;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_hit;
    logic [DATA_WIDTH-1:0]  rdata_one;

    nmi_rr_picker #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req          (s_nmi_valid),
        .rr_ptr       (rr_q),
        .grant_onehot (pick_oh),
        .grant_idx    (pick_idx),
        .any          (pick_any)
    );

    assign next_ptr    = (grant_q == IDX_W'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign s_nmi_rdata = {N_MASTERS{rdata_one}};
    assign dbg_busy    = (state_q == ST_BUSY);

    // Downstream request fields follow the registered grant combinationally.
    always_comb begin
        m_nmi_instr = s_nmi_instr[0];
        m_nmi_addr  = s_nmi_addr[0 +: ADDR_WIDTH];
        m_nmi_wdata = s_nmi_wdata[0 +: DATA_WIDTH];
        m_nmi_wstrb = s_nmi_wstrb[0 +: WSTRB_WIDTH];
        for (int i = 0; i < N_MASTERS; i++) begin
            if (IDX_W'(i) == grant_q) begin
                m_nmi_instr = s_nmi_instr[i];
                m_nmi_addr  = s_nmi_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                m_nmi_wdata = s_nmi_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_nmi_wstrb = s_nmi_wstrb[i*WSTRB_WIDTH +: WSTRB_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_oh_d  = grant_oh_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        m_nmi_valid = 1'b0;
        s_nmi_ready = '0;
        timeout_err = 1'b0;
        rdata_one   = FILL;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    grant_oh_d = pick_oh;
                    cnt_d      = '0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                m_nmi_valid = 1'b1;
                // A real response in the timeout cycle takes priority.
                if (m_nmi_ready) begin
                    s_nmi_ready = grant_oh_q;
                    rdata_one   = m_nmi_rdata;
                    rr_d        = next_ptr;
                    state_d     = ST_IDLE;
                end else if (timeout_hit) begin
                    s_nmi_ready = grant_oh_q;
                    timeout_err = 1'b1;
                    rr_d        = next_ptr;
                    state_d     = ST_IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A reset abandons the transaction; no completion may escape.
        if (rst) begin
            s_nmi_ready = '0;
            timeout_err = 1'b0;
            rdata_one   = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_oh_q <= N_MASTERS'(1);
            rr_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_nmi_arbiter.sv
// Bench for nmi_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_nmi_arbiter;

    localparam int N   = 3;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TO  = 4;
    localparam logic [DW-1:0] FILL = 32'hC0DE_C0DE;

    logic              clk;
    logic              rst;
    logic [N-1:0]      s_nmi_valid;
    logic [N-1:0]      s_nmi_instr;
    logic [N-1:0]      s_nmi_ready;
    logic [N*AW-1:0]   s_nmi_addr;
    logic [N*DW-1:0]   s_nmi_wdata;
    logic [N*SW-1:0]   s_nmi_wstrb;
    logic [N*DW-1:0]   s_nmi_rdata;
    logic              m_nmi_valid;
    logic              m_nmi_instr;
    logic              m_nmi_ready;
    logic [AW-1:0]     m_nmi_addr;
    logic [DW-1:0]     m_nmi_wdata;
    logic [SW-1:0]     m_nmi_wstrb;
    logic [DW-1:0]     m_nmi_rdata;
    logic              timeout_err;
    logic              dbg_busy;

    int vectors;
    int miscompares;

    // Reference model: one outstanding transaction at a time.
    bit busy;
    int grant;
    int ptr;
    int waited;

    nmi_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .N_MASTERS      (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_nmi_valid (s_nmi_valid),
        .s_nmi_instr (s_nmi_instr),
        .s_nmi_ready (s_nmi_ready),
        .s_nmi_addr  (s_nmi_addr),
        .s_nmi_wdata (s_nmi_wdata),
        .s_nmi_wstrb (s_nmi_wstrb),
        .s_nmi_rdata (s_nmi_rdata),
        .m_nmi_valid (m_nmi_valid),
        .m_nmi_instr (m_nmi_instr),
        .m_nmi_ready (m_nmi_ready),
        .m_nmi_addr  (m_nmi_addr),
        .m_nmi_wdata (m_nmi_wdata),
        .m_nmi_wstrb (m_nmi_wstrb),
        .m_nmi_rdata (m_nmi_rdata),
        .timeout_err (timeout_err),
        .dbg_busy    (dbg_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model across a rising edge using the inputs seen before it.
    task automatic model_update();
        bit found;
        int c;
        found = 0;
        if (rst) begin
            busy = 0; ptr = 0; grant = 0; waited = 0;
        end else if (!busy) begin
            for (int k = 0; k < N; k++) begin
                c = (ptr + k) % N;
                if (!found && s_nmi_valid[c]) begin
                    found = 1; grant = c; busy = 1; waited = 0;
                end
            end
        end else begin
            if (m_nmi_ready || waited + 1 == TO) begin
                busy = 0;
                ptr  = (grant + 1) % N;
            end else begin
                waited++;
            end
        end
    endtask

    task automatic model_check();
        logic [N*DW-1:0] exp_rd;
        logic [N-1:0]    exp_ready;
        logic            exp_to;
        exp_rd    = {N{FILL}};
        exp_ready = '0;
        exp_to    = 1'b0;
        if (busy && !rst) begin
            if (m_nmi_ready) begin
                exp_ready = N'(1) << grant;
                exp_rd    = {N{m_nmi_rdata}};
            end else if (waited + 1 == TO) begin
                exp_ready = N'(1) << grant;
                exp_to    = 1'b1;
            end
        end
        chk("m_valid", {{(N*DW-1){1'b0}}, m_nmi_valid}, {{(N*DW-1){1'b0}}, busy});
        chk("s_ready", {{(N*DW-N){1'b0}}, s_nmi_ready}, {{(N*DW-N){1'b0}}, exp_ready});
        chk("timeout_err", {{(N*DW-1){1'b0}}, timeout_err}, {{(N*DW-1){1'b0}}, exp_to});
        chk("s_rdata", s_nmi_rdata, exp_rd);
        if (busy) begin
            chk("m_req", {m_nmi_instr, m_nmi_wstrb, m_nmi_wdata, m_nmi_addr},
                {s_nmi_instr[grant], s_nmi_wstrb[grant*SW +: SW],
                 s_nmi_wdata[grant*DW +: DW], s_nmi_addr[grant*AW +: AW]});
        end
    endtask

    // One clock: update model, drive fresh inputs, check mid-cycle.
    task automatic step(input logic [N-1:0] v, input logic mr, input logic [DW-1:0] rd, input logic r);
        @(posedge clk);
        model_update();
        #1;
        rst         = r;
        s_nmi_valid = v;
        m_nmi_ready = mr;
        m_nmi_rdata = rd;
        for (int i = 0; i < N; i++) begin
            s_nmi_instr[i]          = 1'($urandom);
            s_nmi_addr[i*AW +: AW]  = {2'(i), 14'($urandom)};
            s_nmi_wdata[i*DW +: DW] = $urandom;
            s_nmi_wstrb[i*SW +: SW] = 4'($urandom);
        end
        @(negedge clk);
        model_check();
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        busy = 0; grant = 0; ptr = 0; waited = 0;
        rst = 1'b1; s_nmi_valid = '0; s_nmi_instr = '0; m_nmi_ready = 1'b0;
        m_nmi_rdata = '0; s_nmi_addr = '0; s_nmi_wdata = '0; s_nmi_wstrb = '0;

        step(3'b000, 1'b0, 32'h0, 1'b1);
        step(3'b000, 1'b0, 32'h0, 1'b1);

        // Both low requesters waiting at reset exit: 0 then 1.
        step(3'b011, 1'b1, 32'hAAAA_0000, 1'b0);
        step(3'b011, 1'b1, 32'hAAAA_0001, 1'b0);
        step(3'b010, 1'b1, 32'hAAAA_0002, 1'b0);
        step(3'b010, 1'b1, 32'hAAAA_0003, 1'b0);
        step(3'b000, 1'b0, 32'h0, 1'b0);

        // Slave answers on the third BUSY cycle.
        step(3'b010, 1'b0, 32'h0, 1'b0);
        step(3'b010, 1'b0, 32'h0, 1'b0);
        step(3'b010, 1'b0, 32'h0, 1'b0);
        step(3'b010, 1'b1, 32'h1234_5678, 1'b0);
        step(3'b000, 1'b0, 32'h0, 1'b0);

        // Slave never answers: timeout on the fourth BUSY cycle.
        for (int i = 0; i < 5; i++) step(3'b001, 1'b0, 32'h0, 1'b0);
        step(3'b000, 1'b0, 32'h0, 1'b0);

        // Slave answers exactly on the timeout cycle.
        step(3'b010, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(3'b010, 1'b0, 32'h0, 1'b0);
        step(3'b010, 1'b1, 32'h5555_AAAA, 1'b0);

        // Requester 2 completes with 0 and 2 pending: pointer wraps to 0.
        step(3'b100, 1'b0, 32'h0, 1'b0);
        step(3'b101, 1'b1, 32'h0BAD_F00D, 1'b0);
        step(3'b101, 1'b0, 32'h0, 1'b0);
        step(3'b101, 1'b1, 32'h0000_0001, 1'b0);
        step(3'b000, 1'b0, 32'h0, 1'b0);

        // Reset mid-transaction, with the slave trying to answer.
        step(3'b010, 1'b0, 32'h0, 1'b0);
        step(3'b010, 1'b0, 32'h0, 1'b0);
        step(3'b010, 1'b1, 32'hDEAD_BEEF, 1'b1);
        step(3'b011, 1'b0, 32'h0, 1'b0);
        step(3'b011, 1'b1, 32'h0000_0002, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0), $urandom,
                 ($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nmi_arbiter.md
NMI_ARBITER -- requirements
Module: nmi_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (multiple of 16).
REQ-003 SHALL have parameter N_MASTERS, default 2, number of requesters (1..16).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum BUSY cycles per transaction; 0 disables timeout.
REQ-005 SHALL have derived parameter WSTRB_WIDTH = (DATA_WIDTH-1)/8+1.
REQ-006 SHALL have clk  input  1  sole clock, rising edge.
REQ-007 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have s_nmi_valid  input  N_MASTERS  per-requester request.
REQ-009 SHALL have s_nmi_instr  input  N_MASTERS  per-requester instruction-fetch flag.
REQ-010 SHALL have s_nmi_ready  output  N_MASTERS  per-requester completion strobe.
REQ-011 SHALL have s_nmi_addr / s_nmi_wdata / s_nmi_wstrb  input  N_MASTERS*ADDR_WIDTH / *DATA_WIDTH / *WSTRB_WIDTH  packed, requester i at slice i.
REQ-012 SHALL have s_nmi_rdata  output  N_MASTERS*DATA_WIDTH  read data, identical value in every slice.
REQ-013 SHALL have m_nmi_valid, m_nmi_instr  output  1; m_nmi_ready  input  1; m_nmi_addr, m_nmi_wdata, m_nmi_wstrb  output; m_nmi_rdata  input  DATA_WIDTH  shared downstream port.
REQ-014 SHALL have timeout_err  output  1  one-cycle pulse on timeout completion.

Function
REQ-015 SHALL implement FSM states IDLE and BUSY; reset state IDLE.
REQ-016 In IDLE with any s_nmi_valid high, SHALL register grant = first requester with valid high, searching upward from rr_ptr modulo N_MASTERS, and enter BUSY next cycle.
REQ-017 In IDLE, m_nmi_valid = 0 and all s_nmi_ready = 0.
REQ-018 In BUSY, m_nmi_valid = 1; m_nmi_instr/addr/wdata/wstrb = granted requester's inputs, combinational.
REQ-019 In BUSY with m_nmi_ready = 1, s_nmi_ready[grant] = 1 same cycle, s_nmi_rdata = m_nmi_rdata, other s_nmi_ready = 0; next state IDLE; rr_ptr <= grant+1, wrapping N_MASTERS-1 -> 0.
REQ-020 Minimum request-to-ready latency SHALL be 2 cycles (grant cycle, then BUSY cycle with m_nmi_ready); one IDLE cycle between back-to-back transactions.
REQ-021 Grant SHALL NOT change during BUSY; new requests wait.
REQ-022 Timeout counter SHALL clear on entering BUSY, increment each BUSY cycle with m_nmi_ready = 0.
REQ-023 When TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1 with m_nmi_ready = 0, SHALL complete: s_nmi_ready[grant] = 1, s_nmi_rdata = 16'hC0DE repeated, timeout_err = 1, next state IDLE, rr_ptr advanced as REQ-019.
REQ-024 m_nmi_ready and timeout in same cycle: normal completion SHALL win, timeout_err = 0.
REQ-025 m_nmi_ready while IDLE SHALL be ignored.
REQ-026 Outside completion cycles, s_nmi_rdata = 16'hC0DE repeated.
REQ-027 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1), no wrap.

Reset
REQ-028 rst high SHALL force next cycle: state IDLE, rr_ptr 0, grant 0, counter 0; m_nmi_valid, s_nmi_ready, timeout_err 0.
REQ-029 rst during BUSY SHALL abandon the transaction without any s_nmi_ready pulse.

Structure
REQ-030 Shared package nmi_pkg SHALL hold the state enum and the C0DE fill constant.
REQ-031 Round-robin selection SHALL be sub-module nmi_rr_picker (combinational: req vector + rr_ptr -> one-hot/index + any).

Verification
REQ-032 N=2, both valid at reset exit -> req0 granted first, req1 after req0 ready; each s_nmi_ready 1 cycle.
REQ-033 Slave ready 3 cycles into BUSY, rdata 32'h1234_5678 -> s_nmi_ready[grant] same cycle, rdata 32'h1234_5678.
REQ-034 TIMEOUT_CYCLES = 4, slave never ready -> s_nmi_ready and timeout_err on 4th BUSY cycle, rdata 32'hC0DE_C0DE.
REQ-035 TIMEOUT_CYCLES = 4, m_nmi_ready on 4th BUSY cycle -> normal completion, timeout_err 0.
REQ-036 N=3, grant 2 completes, req0 and req2 pending -> req0 granted (pointer wraps).
REQ-037 rst asserted in BUSY -> m_nmi_valid 0 next cycle, no s_nmi_ready pulse, next grant from requester 0.
